mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_req_fifo.sv | 50 +++++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the cacheline memory responder.
package mem_pkg;

  localparam int LINE_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int INDEX_LSB = 4;
  localparam int INDEX_W   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic               wr;
    logic               client_id;
    logic [INDEX_W-1:0] index;
    logic [LINE_W-1:0]  data;
  } req_t;

  // Reset fill word used when the init-pattern build option is enabled.
  function automatic logic [LINE_W-1:0] init_line(input logic [INDEX_W-1:0] idx);
    return {4{16'hA5A5, 7'b0, idx}};
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Two-entry in-order request queue; entry0 is always the head.
module mem_req_fifo
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  req_t       din,
  output req_t       head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  req_t entry0;
  req_t entry1;
  logic do_push;
  logic do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = entry0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      entry0 <= (do_push && count == 2'd1) ? din : entry1;
      if (do_push && count == 2'd2) entry1 <= din;
    end else if (do_push) begin
      if (empty) entry0 <= din;
      else       entry1 <= din;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency cacheline memory responder with a 2-deep request queue.
// Build option MEM_INIT_PATTERN_EN: reset fills every line with a known pattern.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rden,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LINE_W-1:0] data_in,
  input  logic              client_id_in,
  output logic [LINE_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              client_id_out,
  output logic              busy,
  output logic              overflow
);

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [LINE_W-1:0] lines_mem [LINES];

  req_t       req;
  req_t       head;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       request;
  logic       push;
  logic       drop;
  logic       resp_fire;
  logic       more;
  logic       unused_addr;

  assign unused_addr = ^{addr_in[ADDR_W-1:INDEX_LSB+INDEX_W], addr_in[INDEX_LSB-1:0]};

  assign request = en & (rden | wren);
  assign push    = request & ~full;
  assign drop    = request & full;
  assign busy    = full;

  assign req = '{wr:        wren,
                 client_id: client_id_in,
                 index:     addr_in[INDEX_LSB +: INDEX_W],
                 data:      data_in};

  // The head is in service in WAIT, and in RESP whenever a successor was queued.
  assign resp_fire = ~reset & (cnt == 4'd0) &
                     ((state == WAIT) | ((state == RESP) & ~empty));
  assign more      = (count > 2'd1) | push;

  mem_req_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (resp_fire),
    .din   (req),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      client_id_out  <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (resp_fire) begin
        data_out_valid <= 1'b1;
        data_out       <= head.wr ? head.data : lines_mem[head.index];
        client_id_out  <= head.client_id;
        state          <= RESP;
        // The successor's latency window opens on this response edge.
        if (more) cnt <= LOAD;
      end else begin
        case (state)
          IDLE: begin
            if (push) begin
              state <= WAIT;
              cnt   <= LOAD;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            if (!empty) begin
              state <= WAIT;
              cnt   <= cnt - 4'd1;
            end else if (push) begin
              state <= WAIT;
              cnt   <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
`ifdef MEM_INIT_PATTERN_EN
    if (reset) begin
      for (int i = 0; i < LINES; i++) lines_mem[i] <= init_line(INDEX_W'(i));
    end else
`endif
    if (resp_fire && head.wr) begin
      lines_mem[head.index] <= head.data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         en, rden, wren, client_id_in;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         data_out_valid, client_id_out, busy, overflow;

  logic         l1_en, l1_rden, l1_wren, l1_id_in;
  logic [31:0]  l1_addr;
  logic [127:0] l1_din;
  logic [127:0] l1_dout;
  logic         l1_valid, l1_id_out, l1_busy, l1_overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int           log_cyc[$];
  logic [127:0] log_data[$];
  logic         log_id[$];
  int           l1_cyc[$];
  logic [127:0] l1_data[$];
  logic         l1_idq[$];

  mem_responder #(.LATENCY(4), .LINES(512)) dut (
    .clk(clk), .reset(reset), .en(en), .rden(rden), .wren(wren),
    .addr_in(addr_in), .data_in(data_in), .client_id_in(client_id_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .client_id_out(client_id_out), .busy(busy), .overflow(overflow)
  );

  mem_responder #(.LATENCY(1), .LINES(512)) dut1 (
    .clk(clk), .reset(reset), .en(l1_en), .rden(l1_rden), .wren(l1_wren),
    .addr_in(l1_addr), .data_in(l1_din), .client_id_in(l1_id_in),
    .data_out(l1_dout), .data_out_valid(l1_valid),
    .client_id_out(l1_id_out), .busy(l1_busy), .overflow(l1_overflow)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // A valid raised at edge N is logged with cycle number N.
  always @(negedge clk) begin
    if (data_out_valid === 1'b1) begin
      log_cyc.push_back(cyc);
      log_data.push_back(data_out);
      log_id.push_back(client_id_out);
    end
    if (l1_valid === 1'b1) begin
      l1_cyc.push_back(cyc);
      l1_data.push_back(l1_dout);
      l1_idq.push_back(l1_id_out);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs;
    log_cyc.delete(); log_data.delete(); log_id.delete();
    l1_cyc.delete();  l1_data.delete();  l1_idq.delete();
  endtask

  // Present one request for one edge; t is the edge that samples it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [127:0] d, input logic id, output int t);
    en = 1'b1; rden = rd; wren = wr; addr_in = a; data_in = d; client_id_in = id;
    @(posedge clk);
    #1;
    t = cyc;
    rden = 1'b0; wren = 1'b0;
  endtask

  task automatic issue1(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [127:0] d, input logic id, output int t);
    l1_en = 1'b1; l1_rden = rd; l1_wren = wr; l1_addr = a; l1_din = d; l1_id_in = id;
    @(posedge clk);
    #1;
    t = cyc;
    l1_rden = 1'b0; l1_wren = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    tests++; if (data_out !== 128'd0) begin fails++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    tests++; if (client_id_out !== 1'b0) begin fails++; $display("FAIL reset_client_id: got %b want 0", client_id_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    tests++; if (l1_dout !== 128'd0 || l1_valid !== 1'b0) begin fails++; $display("FAIL reset_l1_outputs: got %h/%b want 0/0", l1_dout, l1_valid); end
  endtask

  task automatic test_read_tag;
    int t;
    logic [127:0] exp;
    exp = {4{32'hA5A5002B}};
`ifndef MEM_INIT_PATTERN_EN
    issue(1'b0, 1'b1, 32'h0000_02B0, exp, 1'b0, t);
    step(6);
`endif
    clear_logs();
    issue(1'b1, 1'b0, 32'h0000_02B1, 128'd0, 1'b1, t);
    step(8);
    tests++; if (log_cyc.size() != 1) begin fails++; $display("FAIL read_count: got %0d want 1", log_cyc.size()); end
    if (log_cyc.size() > 0) begin
      tests++; if (log_cyc[0] != t + 4) begin fails++; $display("FAIL read_cycle: got %0d want %0d", log_cyc[0], t + 4); end
      tests++; if (log_data[0] !== exp) begin fails++; $display("FAIL read_data: got %h want %h", log_data[0], exp); end
      tests++; if (log_id[0] !== 1'b1) begin fails++; $display("FAIL read_id: got %b want 1", log_id[0]); end
    end
    tests++; if (data_out !== exp || client_id_out !== 1'b1) begin fails++; $display("FAIL read_hold: got %h/%b want %h/1", data_out, client_id_out, exp); end
  endtask

  task automatic test_write_read;
    int t, t2;
    logic [127:0] line;
    line = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    clear_logs();
    issue(1'b0, 1'b1, 32'h0000_0040, line, 1'b0, t);
    issue(1'b1, 1'b0, 32'h0000_0040, 128'd0, 1'b1, t2);
    step(10);
    tests++; if (log_cyc.size() != 2) begin fails++; $display("FAIL wr_rd_count: got %0d want 2", log_cyc.size()); end
    if (log_cyc.size() > 1) begin
      tests++; if (log_cyc[0] != t + 4 || log_cyc[1] != t + 8) begin fails++; $display("FAIL wr_rd_cycles: got %0d,%0d want %0d,%0d", log_cyc[0], log_cyc[1], t + 4, t + 8); end
      tests++; if (log_data[0] !== line) begin fails++; $display("FAIL wr_ack_data: got %h want %h", log_data[0], line); end
      tests++; if (log_data[1] !== line) begin fails++; $display("FAIL rd_after_wr_data: got %h want %h", log_data[1], line); end
      tests++; if (log_id[0] !== 1'b0 || log_id[1] !== 1'b1) begin fails++; $display("FAIL wr_rd_ids: got %b,%b want 0,1", log_id[0], log_id[1]); end
    end
  endtask

  task automatic test_overflow;
    int t, t2, t3;
    clear_logs();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_initial: got %b want 0", overflow); end
    issue(1'b1, 1'b0, 32'h0000_0040, 128'd0, 1'b0, t);
    issue(1'b1, 1'b0, 32'h0000_02B0, 128'd0, 1'b1, t2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy: got %b want 1", busy); end
    issue(1'b1, 1'b0, 32'h0000_0040, 128'd0, 1'b1, t3);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
    step(12);
    tests++; if (log_cyc.size() != 2) begin fails++; $display("FAIL ovf_resp_count: got %0d want 2", log_cyc.size()); end
    if (log_cyc.size() > 1) begin
      tests++; if (log_cyc[0] != t + 4 || log_cyc[1] != t + 8) begin fails++; $display("FAIL ovf_resp_cycles: got %0d,%0d want %0d,%0d", log_cyc[0], log_cyc[1], t + 4, t + 8); end
      tests++; if (log_id[0] !== 1'b0 || log_id[1] !== 1'b1) begin fails++; $display("FAIL ovf_resp_ids: got %b,%b want 0,1", log_id[0], log_id[1]); end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_drain: got %b want 0", busy); end
  endtask

  task automatic test_enable;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    clear_logs();
    en = 1'b0; rden = 1'b1; addr_in = 32'h0000_0040;
    step(3);
    rden = 1'b0;
    step(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL en_busy: got %b want 0", busy); end
    en = 1'b1;
    step(6);
    tests++; if (log_cyc.size() != 0) begin fails++; $display("FAIL en_no_resp: got %0d responses want 0", log_cyc.size()); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL en_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid;
    int t, t2;
    logic [127:0] line, exp;
    line = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
`ifdef MEM_INIT_PATTERN_EN
    exp = {4{32'hA5A50010}};
`else
    exp = line;
`endif
    issue(1'b0, 1'b1, 32'h0000_0100, line, 1'b0, t);
    step(6);
    clear_logs();
    issue(1'b1, 1'b0, 32'h0000_0100, 128'd0, 1'b0, t);
    issue(1'b1, 1'b0, 32'h0000_0040, 128'd0, 1'b1, t2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    tests++; if (log_cyc.size() != 0) begin fails++; $display("FAIL mid_no_resp: got %0d responses want 0", log_cyc.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL mid_state: got %0d want %0d", dut.state, IDLE); end
    issue(1'b1, 1'b0, 32'h0000_0100, 128'd0, 1'b1, t);
    step(5);
    tests++; if (log_cyc.size() != 1) begin fails++; $display("FAIL mid_readback_count: got %0d want 1", log_cyc.size()); end
    if (log_cyc.size() > 0) begin
      tests++; if (log_data[0] !== exp) begin fails++; $display("FAIL mid_readback_data: got %h want %h", log_data[0], exp); end
    end
  endtask

  task automatic test_latency1;
    int t, t2;
    logic [127:0] la, lb;
    la = 128'h11112222_33334444_55556666_77778888;
    lb = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
    clear_logs();
    issue1(1'b0, 1'b1, 32'h0000_0010, la, 1'b0, t);
    issue1(1'b0, 1'b1, 32'h0000_0020, lb, 1'b1, t2);
    step(3);
    tests++; if (l1_cyc.size() != 2) begin fails++; $display("FAIL l1_wr_count: got %0d want 2", l1_cyc.size()); end
    if (l1_cyc.size() > 1) begin
      tests++; if (l1_cyc[0] != t + 1 || l1_cyc[1] != t + 2) begin fails++; $display("FAIL l1_wr_cycles: got %0d,%0d want %0d,%0d", l1_cyc[0], l1_cyc[1], t + 1, t + 2); end
    end
    clear_logs();
    issue1(1'b1, 1'b0, 32'h0000_0010, 128'd0, 1'b1, t);
    issue1(1'b1, 1'b0, 32'h0000_0020, 128'd0, 1'b0, t2);
    step(3);
    tests++; if (l1_cyc.size() != 2) begin fails++; $display("FAIL l1_rd_count: got %0d want 2", l1_cyc.size()); end
    if (l1_cyc.size() > 1) begin
      tests++; if (l1_cyc[0] != t + 1 || l1_cyc[1] != t + 2) begin fails++; $display("FAIL l1_rd_cycles: got %0d,%0d want %0d,%0d", l1_cyc[0], l1_cyc[1], t + 1, t + 2); end
      tests++; if (l1_data[0] !== la || l1_data[1] !== lb) begin fails++; $display("FAIL l1_rd_data: got %h,%h want %h,%h", l1_data[0], l1_data[1], la, lb); end
      tests++; if (l1_idq[0] !== 1'b1 || l1_idq[1] !== 1'b0) begin fails++; $display("FAIL l1_rd_ids: got %b,%b want 1,0", l1_idq[0], l1_idq[1]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1; rden = 1'b0; wren = 1'b0; addr_in = '0; data_in = '0; client_id_in = 1'b0;
    l1_en = 1'b1; l1_rden = 1'b0; l1_wren = 1'b0; l1_addr = '0; l1_din = '0; l1_id_in = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    test_reset();
    test_read_tag();
    test_write_read();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
